// File: rtl/seq_pkg.sv
// Shared sequencer types: control op encoding, FSM states, default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

   // Default sizing shared with the PC and instruction-memory blocks
   localparam int SEQ_AW       = 5;
   localparam int SEQ_PROG_LEN = 20;

   // Decoded control op for the instruction at pc; codes 6 and 7 are reserved
   typedef enum logic [2:0] {
      OP_SEQ    = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_HALT   = 3'd5
   } seq_op_t;

   // Sequencer run state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } seq_state_t;

endpackage : seq_pkg

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of AW-bit addresses, one push or pop per cycle.
// Latency: dout shows the top entry combinationally; push/pop take effect at the edge.
// Backpressure: none; push when full and pop when empty are silently ignored.
module ras_stack #(
   parameter  int AW          = 5,
   parameter  int STACK_DEPTH = 4,
   localparam int DW          = $clog2(STACK_DEPTH + 1),
   localparam int IW          = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
   input  logic          clock,
   input  logic          clear_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] depth
);

   logic [AW-1:0] mem_q [STACK_DEPTH];
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;
   logic [DW-1:0] top_c;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt_q == DW'(STACK_DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty && !push;
   assign top_c   = cnt_q - DW'(1);
   assign dout    = mem_q[top_c[IW-1:0]];
   assign depth   = cnt_q;

   // Occupancy follows the accepted push/pop
   always_comb begin
      cnt_d = cnt_q;
      if (do_push) begin
         cnt_d = cnt_q + DW'(1);
      end else if (do_pop) begin
         cnt_d = cnt_q - DW'(1);
      end
   end

   // Occupancy register; contents are don't-care after reset so only the count resets
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Entry storage, written at the slot just above the current top
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[cnt_q[IW-1:0]] <= din;
      end
   end

endmodule : ras_stack

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: run/idle/halt FSM, next-PC mux, return stack, range check, sticky errors.
// Latency: op/cond/target sampled at an edge produce the new pc right after that edge.
// Backpressure: stall freezes pc, state, stack and errors; pc_valid drops while stalled.
module pc_sequencer
   import seq_pkg::*;
#(
   parameter  int AW          = SEQ_AW,
   parameter  int PROG_LEN    = SEQ_PROG_LEN,
   parameter  int STACK_DEPTH = 4,
   localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
   input  logic          clock,
   input  logic          clear_n,
   input  logic          start,
   input  logic          stall,
   input  seq_op_t       op,
   input  logic          cond,
   input  logic [AW-1:0] target,
   output logic [AW-1:0] pc,
   output logic          pc_valid,
   output logic          halted,
   output logic [DW-1:0] depth,
   output logic [1:0]    err
);

   localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);
   localparam logic [AW:0]   LEN_X   = (AW + 1)'(PROG_LEN);

   // Sequential successor with wrap at the last legal address
   function automatic logic [AW-1:0] seq_next(input logic [AW-1:0] p);
      return (p == LAST_PC) ? '0 : p + AW'(1);
   endfunction

   seq_state_t    state_q, state_d;
   logic          halted_q;
   logic [AW-1:0] pc_q, pc_d;
   logic [1:0]    err_q, err_d;

   logic          run_go;
   logic          start_go;
   logic          tgt_bad;
   logic [AW-1:0] tgt_pc;

   logic          ras_push;
   logic          ras_pop;
   logic [AW-1:0] ras_dout;
   logic          ras_full;
   logic          ras_empty;

   // An op is acted on only in RUN and unstalled; start only when not already running
   assign run_go   = (state_q == ST_RUN) && !stall;
   assign start_go = start && !stall && (state_q != ST_RUN);

   // Out-of-range destinations redirect to address 0
   assign tgt_bad = ({1'b0, target} >= LEN_X);
   assign tgt_pc  = tgt_bad ? '0 : target;

   ras_stack #(
      .AW          (AW),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ras (
      .clock   (clock),
      .clear_n (clear_n),
      .push    (ras_push),
      .pop     (ras_pop),
      .din     (seq_next(pc_q)),
      .dout    (ras_dout),
      .full    (ras_full),
      .empty   (ras_empty),
      .depth   (depth)
   );

   // FSM state register; halted is registered off the next state
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q  <= ST_IDLE;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == ST_HALT);
      end
   end

   // FSM next state: start leaves IDLE/HALT, a HALT op leaves RUN, stall freezes all
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start_go) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (run_go && (op == OP_HALT)) state_d = ST_HALT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: fetch enable is live only while running and unstalled
   always_comb begin
      pc_valid = (state_q == ST_RUN) && !stall;
      halted   = halted_q;
   end

   // Next-PC mux, stack control and sticky error update
   always_comb begin
      pc_d     = pc_q;
      err_d    = err_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      if (start_go) begin
         // Accepted start clears errors; resuming from HALT skips the HALT instruction
         err_d = '0;
         if (state_q == ST_HALT) pc_d = seq_next(pc_q);
      end else if (run_go) begin
         case (op)
            OP_JUMP: begin
               pc_d = tgt_pc;
               if (tgt_bad) err_d[1] = 1'b1;
            end
            OP_BRANCH: begin
               if (cond) begin
                  pc_d = tgt_pc;
                  if (tgt_bad) err_d[1] = 1'b1;
               end else begin
                  pc_d = seq_next(pc_q);
               end
            end
            OP_CALL: begin
               // The jump is taken even when the return address cannot be saved
               pc_d = tgt_pc;
               if (tgt_bad) err_d[1] = 1'b1;
               if (ras_full) err_d[0] = 1'b1;
               else          ras_push = 1'b1;
            end
            OP_RET: begin
               if (ras_empty) begin
                  err_d[0] = 1'b1;
                  pc_d     = seq_next(pc_q);
               end else begin
                  ras_pop = 1'b1;
                  pc_d    = ras_dout;
               end
            end
            OP_HALT: pc_d = pc_q;
            default: pc_d = seq_next(pc_q);
         endcase
      end
   end

   // PC and error registers
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         pc_q  <= '0;
         err_q <= '0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   assign pc  = pc_q;
   assign err = err_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: stall exercised directly.
module tb_pc_sequencer;
   import seq_pkg::*;

   logic          clock;
   logic          clear_n;
   logic          start;
   logic          stall;
   seq_op_t       op;
   logic          cond;
   logic [4:0]    target;
   logic [4:0]    pc;
   logic          pc_valid;
   logic          halted;
   logic [2:0]    depth;
   logic [1:0]    err;

   int n_chk = 0;
   int n_err = 0;

   pc_sequencer #(
      .AW          (5),
      .PROG_LEN    (20),
      .STACK_DEPTH (4)
   ) dut (
      .clock    (clock),
      .clear_n  (clear_n),
      .start    (start),
      .stall    (stall),
      .op       (op),
      .cond     (cond),
      .target   (target),
      .pc       (pc),
      .pc_valid (pc_valid),
      .halted   (halted),
      .depth    (depth),
      .err      (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Full visible-state comparison
   task automatic expect_all(input string tag, input int pc_e, input int depth_e,
                             input int err_e, input int halted_e, input int valid_e);
      check({tag, ".pc"},       32'(pc),       32'(pc_e));
      check({tag, ".depth"},    32'(depth),    32'(depth_e));
      check({tag, ".err"},      32'(err),      32'(err_e));
      check({tag, ".halted"},   32'(halted),   32'(halted_e));
      check({tag, ".pc_valid"}, 32'(pc_valid), 32'(valid_e));
   endtask

   // Drive one cycle's inputs, then sample just after the edge
   task automatic step(input seq_op_t o, input logic c, input logic [4:0] t);
      op     = o;
      cond   = c;
      target = t;
      @(posedge clock);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step(OP_SEQ, 1'b0, 5'd0);
      start = 1'b0;
   endtask

   initial begin
      clear_n = 1'b0;
      start   = 1'b0;
      stall   = 1'b0;
      op      = OP_SEQ;
      cond    = 1'b0;
      target  = '0;
      #2;
      expect_all("reset", 0, 0, 0, 0, 0);
      #10 clear_n = 1'b1;

      // IDLE ignores ops without start
      step(OP_JUMP, 1'b0, 5'd5);
      expect_all("idle_hold", 0, 0, 0, 0, 0);

      // Start: first fetch is address 0
      do_start();
      expect_all("start", 0, 0, 0, 0, 1);

      // Wrap: 0..19 then back to 0
      for (int i = 1; i <= 20; i++) begin
         step(OP_SEQ, 1'b0, 5'd0);
         check($sformatf("wrap.pc%0d", i), 32'(pc), 32'(i % 20));
         check($sformatf("wrap.vld%0d", i), 32'(pc_valid), 32'd1);
      end
      check("wrap.err", 32'(err), 32'd0);

      // Jump and range check
      for (int i = 0; i < 3; i++) step(OP_SEQ, 1'b0, 5'd0);
      check("pre_jump.pc", 32'(pc), 32'd3);
      step(OP_JUMP, 1'b0, 5'd7);
      expect_all("jump7", 7, 0, 0, 0, 1);
      step(OP_JUMP, 1'b0, 5'd25);
      expect_all("jump25", 0, 0, 2, 0, 1);
      step(OP_HALT, 1'b0, 5'd0);
      expect_all("halt_err", 0, 0, 2, 1, 0);
      do_start();
      expect_all("start_clr", 1, 0, 0, 0, 1);

      // Branch
      for (int i = 0; i < 3; i++) step(OP_SEQ, 1'b0, 5'd0);
      check("pre_br.pc", 32'(pc), 32'd4);
      step(OP_BRANCH, 1'b0, 5'd12);
      check("br_nt.pc", 32'(pc), 32'd5);
      step(OP_BRANCH, 1'b1, 5'd12);
      check("br_t.pc", 32'(pc), 32'd12);

      // Call / return
      step(OP_JUMP, 1'b0, 5'd2);
      step(OP_CALL, 1'b0, 5'd10);
      expect_all("call1", 10, 1, 0, 0, 1);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("ret1", 3, 0, 0, 0, 1);

      // Nested calls up to overflow, then LIFO unwind
      step(OP_CALL, 1'b0, 5'd10);
      step(OP_CALL, 1'b0, 5'd11);
      step(OP_CALL, 1'b0, 5'd12);
      step(OP_CALL, 1'b0, 5'd13);
      expect_all("call4", 13, 4, 0, 0, 1);
      step(OP_CALL, 1'b0, 5'd14);
      expect_all("call5_ovf", 14, 4, 1, 0, 1);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("unw1", 13, 3, 1, 0, 1);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("unw2", 12, 2, 1, 0, 1);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("unw3", 11, 1, 1, 0, 1);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("unw4", 4, 0, 1, 0, 1);

      // Clear err, then underflow
      step(OP_HALT, 1'b0, 5'd0);
      do_start();
      expect_all("restart", 5, 0, 0, 0, 1);
      step(OP_JUMP, 1'b0, 5'd8);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("ret_unf", 9, 0, 1, 0, 1);

      // CALL to bad target still pushes its return address
      step(OP_CALL, 1'b0, 5'd30);
      expect_all("call_bad", 0, 1, 3, 0, 1);
      step(OP_RET, 1'b0, 5'd0);
      expect_all("ret_bad", 10, 0, 3, 0, 1);

      // Halt holds for 5 cycles; stalled start ignored; start resumes at pc+1
      step(OP_JUMP, 1'b0, 5'd6);
      step(OP_HALT, 1'b0, 5'd0);
      expect_all("halt6", 6, 0, 3, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(OP_JUMP, 1'b0, 5'd1);
         expect_all($sformatf("halt_hold%0d", i), 6, 0, 3, 1, 0);
      end
      stall = 1'b1;
      do_start();
      stall = 1'b0;
      expect_all("halt_stall_start", 6, 0, 3, 1, 0);
      do_start();
      expect_all("resume", 7, 0, 0, 0, 1);

      // Reserved op codes behave as SEQ
      step(seq_op_t'(3'd6), 1'b1, 5'd15);
      check("rsv6.pc", 32'(pc), 32'd8);
      step(seq_op_t'(3'd7), 1'b1, 5'd15);
      check("rsv7.pc", 32'(pc), 32'd9);

      // Stall freezes everything, even HALT and CALL
      stall = 1'b1;
      #1;
      check("stall.vld_comb", 32'(pc_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(OP_JUMP, 1'b0, 5'd15);
         expect_all($sformatf("stall%0d", i), 9, 0, 0, 0, 0);
      end
      step(OP_HALT, 1'b0, 5'd0);
      expect_all("stall_halt", 9, 0, 0, 0, 0);
      step(OP_CALL, 1'b0, 5'd25);
      expect_all("stall_call", 9, 0, 0, 0, 0);
      stall = 1'b0;
      #1;
      check("unstall.vld", 32'(pc_valid), 32'd1);

      // Asynchronous reset mid-cycle with pc=9, depth=2
      step(OP_CALL, 1'b0, 5'd9);
      step(OP_CALL, 1'b0, 5'd9);
      expect_all("pre_rst", 9, 2, 0, 0, 1);
      #3;
      clear_n = 1'b0;
      #1;
      expect_all("async_rst", 0, 0, 0, 0, 0);
      step(OP_SEQ, 1'b0, 5'd0);
      expect_all("rst_held", 0, 0, 0, 0, 0);
      #2 clear_n = 1'b1;
      do_start();
      expect_all("post_rst_start", 0, 0, 0, 0, 1);
      step(OP_SEQ, 1'b0, 5'd0);
      check("post_rst.pc", 32'(pc), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_pc_sequencer
